// File: rtl/logic_bus_arb.sv
// logic_bus_arb: two-requester round-robin arbiter for the 12-bit address /
// 16-bit data logic register bus. One owner at a time is forwarded to the
// single register-file target. Its address, write data and operation are
// latched when it is granted. Read data and a one-cycle ack are returned to
// the owner.
//
// Optional feature: define LOGIC_ARB_TIMEOUT_EN to abort a target access
// that is not acknowledged within TIMEOUT_CYC cycles. An aborted access
// returns TO_RD_DATA and pulses timeout_err. Without the macro, an access
// waits for logic_ack indefinitely and timeout_err is tied to 0.
module logic_bus_arb #(
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [15:0] TO_RD_DATA  = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] m0_adr,
  input  logic [15:0] m0_wr_data,
  input  logic        m0_wr_req,
  input  logic        m0_rd_req,
  output logic [15:0] m0_rd_data,
  output logic        m0_ack,
  input  logic [11:0] m1_adr,
  input  logic [15:0] m1_wr_data,
  input  logic        m1_wr_req,
  input  logic        m1_rd_req,
  output logic [15:0] m1_rd_data,
  output logic        m1_ack,
  output logic [11:0] logic_adr,
  output logic [15:0] logic_wr_data,
  output logic        logic_wr_req,
  output logic        logic_rd_req,
  input  logic [15:0] logic_rd_data,
  input  logic        logic_ack,
  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP, ST_RELEASE} state_t;

  state_t state_reg, state_next;
  logic   last_reg;      // index of the requester served most recently
  logic   m0_active, m1_active, owner_active;
  logic   take, take_sel, take_wr;
  logic   done, abort, expire;

  // A timeout of zero cycles is meaningless; stop elaboration instead.
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("logic_bus_arb: TIMEOUT_CYC must be at least 1");
  end

  assign m0_active    = m0_wr_req | m0_rd_req;
  assign m1_active    = m1_wr_req | m1_rd_req;
  assign owner_active = grant ? m1_active : m0_active;
  assign busy         = (state_reg != ST_IDLE);

`ifdef LOGIC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] to_cnt_reg;

  // The counter is held at 0 outside ISSUE and counts the ISSUE cycles elapsed.
  // It therefore restarts from 0 on every entry to ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      to_cnt_reg <= '0;
    else if (state_reg != ST_ISSUE) to_cnt_reg <= '0;
    else                          to_cnt_reg <= to_cnt_reg + 1'b1;
  end

  // Expiry is reached on the last allowed ISSUE cycle.
  assign expire = (to_cnt_reg == CW'(TIMEOUT_CYC - 1));

  // The error flag pulses alongside the owner's ack when an access is aborted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_err <= 1'b0;
    else     timeout_err <= abort;
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Transaction state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next state plus grant/complete strobes. If both requesters are active, the
  // one not served last wins. logic_ack beats a simultaneous expiry.
  always_comb begin
    state_next = state_reg;
    take       = 1'b0;
    take_sel   = 1'b0;
    take_wr    = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (m0_active | m1_active) begin
          take       = 1'b1;
          take_sel   = (m0_active & m1_active) ? ~last_reg : m1_active;
          take_wr    = take_sel ? m1_wr_req : m0_wr_req;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (logic_ack) begin
          done       = 1'b1;
          state_next = ST_RESP;
        end else if (expire) begin
          abort      = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP:    state_next = ST_RELEASE;
      ST_RELEASE: if (!owner_active) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Datapath: latch the winner's request, drive the target, and return the
  // ack and read data to the owner. Read data only changes on a read
  // completion or on an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_reg      <= 1'b1;
      grant         <= 1'b0;
      logic_adr     <= '0;
      logic_wr_data <= '0;
      logic_wr_req  <= 1'b0;
      logic_rd_req  <= 1'b0;
      m0_ack        <= 1'b0;
      m1_ack        <= 1'b0;
      m0_rd_data    <= '0;
      m1_rd_data    <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      if (take) begin
        grant         <= take_sel;
        last_reg      <= take_sel;
        logic_adr     <= take_sel ? m1_adr : m0_adr;
        logic_wr_data <= take_sel ? m1_wr_data : m0_wr_data;
        logic_wr_req  <= take_wr;
        logic_rd_req  <= ~take_wr;
      end
      if (done || abort) begin
        logic_wr_req <= 1'b0;
        logic_rd_req <= 1'b0;
        m0_ack       <= ~grant;
        m1_ack       <= grant;
      end
      if ((done && logic_rd_req) || abort) begin
        if (grant) m1_rd_data <= done ? logic_rd_data : TO_RD_DATA;
        else       m0_rd_data <= done ? logic_rd_data : TO_RD_DATA;
      end
    end
  end

endmodule
